// File: rtl/remote_comm_if.sv
// Host-side command/response bundle for remote_comm: command strobe, serial lines, response.
// The master modport is the host/bench side, the slave modport is the link itself.
interface remote_comm_if;
   logic        send_cmd;
   logic [15:0] cmd;
   logic        cmd_sent;
   logic        TX;
   logic        RX;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        clr_resp_rdy;

   modport master (
      output send_cmd,
      output cmd,
      output RX,
      output clr_resp_rdy,
      input  cmd_sent,
      input  TX,
      input  resp,
      input  resp_rdy
   );

   modport slave (
      input  send_cmd,
      input  cmd,
      input  RX,
      input  clr_resp_rdy,
      output cmd_sent,
      output TX,
      output resp,
      output resp_rdy
   );
endinterface

// File: rtl/remote_comm.sv
// Knight's Tour host command link: sends a 16-bit command as two 8N1 frames (high byte first)
// and receives single-byte 8N1 responses. TX and RX paths are independent.
module remote_comm #(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic          clk,
   input  logic          RST_n,
   remote_comm_if.slave  bus
);

   localparam logic [11:0] BaudDiv  = 12'(BAUD_DIV);
   localparam logic [11:0] BaudLast = 12'(BAUD_DIV - 1);
   localparam logic [11:0] BaudHalf = 12'(BAUD_DIV / 2);

   // ---------------------------------------------------------------------------------------------
   // Transmit path
   // ---------------------------------------------------------------------------------------------
   typedef enum logic [1:0] {TxIdle, TxHigh, TxLow, TxDone} tx_state_e;

   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] cmd_hold_q, cmd_hold_d;
   logic [9:0]  tx_shift_q, tx_shift_d;
   logic [11:0] tx_baud_q,  tx_baud_d;
   logic [3:0]  tx_bit_q,   tx_bit_d;
   logic        cmd_sent_q, cmd_sent_d;

   always_comb begin
      tx_state_d = tx_state_q;
      cmd_hold_d = cmd_hold_q;
      tx_shift_d = tx_shift_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      cmd_sent_d = cmd_sent_q;

      unique case (tx_state_q)
         TxIdle: begin
            if (bus.send_cmd) begin
               cmd_hold_d = bus.cmd;
               cmd_sent_d = 1'b0;
               tx_shift_d = {1'b1, bus.cmd[15:8], 1'b0};
               tx_baud_d  = '0;
               tx_bit_d   = '0;
               tx_state_d = TxHigh;
            end
         end
         TxHigh, TxLow: begin
            if (tx_baud_q == BaudLast) begin
               tx_baud_d = '0;
               if (tx_bit_q == 4'd9) begin
                  tx_bit_d = '0;
                  if (tx_state_q == TxHigh) begin
                     // Low frame follows the high stop bit with no idle gap.
                     tx_shift_d = {1'b1, cmd_hold_q[7:0], 1'b0};
                     tx_state_d = TxLow;
                  end else begin
                     tx_shift_d = '1;
                     tx_state_d = TxDone;
                  end
               end else begin
                  tx_shift_d = {1'b1, tx_shift_q[9:1]};
                  tx_bit_d   = tx_bit_q + 4'd1;
               end
            end else begin
               tx_baud_d = tx_baud_q + 12'd1;
            end
         end
         TxDone: begin
            cmd_sent_d = 1'b1;
            tx_state_d = TxIdle;
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RST_n) begin
         tx_state_q <= TxIdle;
         cmd_hold_q <= '0;
         tx_shift_q <= '1;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         cmd_sent_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         cmd_hold_q <= cmd_hold_d;
         tx_shift_q <= tx_shift_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         cmd_sent_q <= cmd_sent_d;
      end
   end

   // Upper byte of the held command is retained for observability only.
   logic unused_hold_hi;
   assign unused_hold_hi = ^cmd_hold_q[15:8];

   assign bus.TX       = tx_shift_q[0];
   assign bus.cmd_sent = cmd_sent_q;

   // ---------------------------------------------------------------------------------------------
   // Receive path
   // ---------------------------------------------------------------------------------------------
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   rx_state_e   rx_state_q, rx_state_d;
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   logic [11:0] rx_cnt_q,   rx_cnt_d;
   logic [2:0]  rx_bit_q,   rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  resp_q,     resp_d;
   logic        resp_rdy_q, resp_rdy_d;
   logic        rx_fall;
   logic        rx_tick;

   assign rx_fall = rx_prev_q & ~rx_sync_q;
   assign rx_tick = (rx_cnt_q == 12'd1);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      resp_d     = resp_q;
      resp_rdy_d = resp_rdy_q;

      if (bus.clr_resp_rdy) begin
         resp_rdy_d = 1'b0;
      end

      if (rx_state_q != RxIdle) begin
         rx_cnt_d = rx_tick ? BaudDiv : rx_cnt_q - 12'd1;
      end

      unique case (rx_state_q)
         RxIdle: begin
            if (rx_fall) begin
               rx_cnt_d   = BaudHalf;
               resp_rdy_d = 1'b0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_tick) begin
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_tick) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end
            end
         end
         RxStop: begin
            if (rx_tick) begin
               // A low stop bit is a framing error: the byte is dropped silently.
               if (rx_sync_q) begin
                  resp_d     = rx_shift_q;
                  resp_rdy_d = 1'b1;
               end
               rx_state_d = RxIdle;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RST_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         resp_q     <= '0;
         resp_rdy_q <= 1'b0;
      end else begin
         rx_meta_q  <= bus.RX;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         resp_q     <= resp_d;
         resp_rdy_q <= resp_rdy_d;
      end
   end

   assign bus.resp     = resp_q;
   assign bus.resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm at BAUD_DIV=16: drivers push expected frames, responses and
// cmd_sent rise cycles into queues; independent monitors pop and compare.
module tb_remote_comm;
   localparam int unsigned BD     = 16;
   localparam int unsigned RxLat  = 3 + BD / 2 + 9 * BD;
   localparam int unsigned TxLat  = 20 * BD + 1;

   typedef struct {
      logic [7:0]  data;
      int unsigned cyc;
   } resp_exp_t;

   logic        clk = 1'b0;
   logic        RST_n;
   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   bit          tx_mon_en = 1'b1;

   logic [9:0]  tx_exp_q[$];
   resp_exp_t   resp_exp_q[$];
   int unsigned sent_exp_q[$];

   remote_comm_if bus ();

   remote_comm #(.BAUD_DIV(BD)) dut (
      .clk   (clk),
      .RST_n (RST_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_cyc(input string name, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got + 1 < exp || got > exp + 1) begin
         n_err++;
         $display("FAIL %s: got cycle %0d expected %0d (+-1)", name, got, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   // TX monitor: samples each frame mid-bit.
   initial begin : tx_mon
      logic [9:0] fr;
      bit         en;
      forever begin
         @(negedge clk);
         if (bus.TX === 1'b0) begin
            en = tx_mon_en;
            repeat (BD / 2 - 1) @(negedge clk);
            fr[0] = bus.TX;
            for (int i = 1; i < 10; i++) begin
               repeat (BD) @(negedge clk);
               fr[i] = bus.TX;
            end
            if (en) begin
               if (tx_exp_q.size() == 0) unexpected("tx_frame");
               else check("tx_frame", 32'(fr), 32'(tx_exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : resp_mon
      logic      prev;
      resp_exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.resp_rdy === 1'b1 && !prev) begin
            if (resp_exp_q.size() == 0) begin
               unexpected("resp_rdy");
            end else begin
               e = resp_exp_q.pop_front();
               check("resp", 32'(bus.resp), 32'(e.data));
               check_cyc("resp_lat", cyc, e.cyc);
            end
         end
         prev = (bus.resp_rdy === 1'b1);
      end
   end

   initial begin : sent_mon
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.cmd_sent === 1'b1 && !prev) begin
            if (sent_exp_q.size() == 0) unexpected("cmd_sent");
            else check_cyc("cmd_sent_lat", cyc, sent_exp_q.pop_front());
         end
         prev = (bus.cmd_sent === 1'b1);
      end
   end

   task automatic send(input logic [15:0] c, input bit expect_it);
      int unsigned n0;
      @(negedge clk);
      bus.cmd      = c;
      bus.send_cmd = 1'b1;
      n0 = cyc + 1;
      if (expect_it) begin
         tx_exp_q.push_back({1'b1, c[15:8], 1'b0});
         tx_exp_q.push_back({1'b1, c[7:0], 1'b0});
         sent_exp_q.push_back(n0 + TxLat);
      end
      @(negedge clk);
      bus.send_cmd = 1'b0;
      check("cmd_sent_fall", 32'(bus.cmd_sent), 32'd0);
   endtask

   task automatic wait_sent();
      int k;
      k = 0;
      while (bus.cmd_sent !== 1'b1 && k < 30 * BD) begin
         @(negedge clk);
         k++;
      end
      check("cmd_sent_seen", 32'(bus.cmd_sent), 32'd1);
   endtask

   task automatic rx_send(input logic [7:0] b, input bit stop, input bit expect_it);
      resp_exp_t e;
      @(negedge clk);
      bus.RX = 1'b0;
      if (expect_it) begin
         e.data = b;
         e.cyc  = cyc + RxLat;
         resp_exp_q.push_back(e);
      end
      repeat (5) @(negedge clk);
      check("rdy_clr_on_start", 32'(bus.resp_rdy), 32'd0);
      repeat (BD - 5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.RX = b[i];
         repeat (BD) @(negedge clk);
      end
      bus.RX = stop;
      repeat (BD) @(negedge clk);
      bus.RX = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      RST_n            = 1'b0;
      bus.RX           = 1'b1;
      bus.send_cmd     = 1'b0;
      bus.cmd          = '0;
      bus.clr_resp_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_TX", 32'(bus.TX), 32'd1);
      check("rst_cmd_sent", 32'(bus.cmd_sent), 32'd0);
      check("rst_resp", 32'(bus.resp), 32'h00);
      check("rst_resp_rdy", 32'(bus.resp_rdy), 32'd0);
      RST_n = 1'b1;

      // Full duplex: command out while two responses come in.
      fork
         begin
            send(16'h2000, 1'b1);
            wait_sent();
         end
         begin
            rx_send(8'hA5, 1'b1, 1'b1);
            rx_send(8'h5A, 1'b1, 1'b1);
         end
      join
      repeat (10) @(negedge clk);

      // A second strobe during bit 5 must be ignored.
      send(16'h2000, 1'b1);
      repeat (5 * BD + 5) @(negedge clk);
      bus.cmd      = 16'h4321;
      bus.send_cmd = 1'b1;
      @(negedge clk);
      bus.send_cmd = 1'b0;
      wait_sent();
      check("cmd_hold", 32'(dut.cmd_hold_q), 32'h2000);
      repeat (30) @(negedge clk);

      bus.clr_resp_rdy = 1'b1;
      @(negedge clk);
      bus.clr_resp_rdy = 1'b0;
      check("clr_resp_rdy", 32'(bus.resp_rdy), 32'd0);

      rx_send(8'h3C, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      check("frame_err_resp", 32'(bus.resp), 32'h5A);
      check("frame_err_rdy", 32'(bus.resp_rdy), 32'd0);

      bus.RX = 1'b0;
      repeat (4) @(negedge clk);
      bus.RX = 1'b1;
      repeat (12 * BD) @(negedge clk);
      check("glitch_resp", 32'(bus.resp), 32'h5A);
      check("glitch_rdy", 32'(bus.resp_rdy), 32'd0);

      // clr held through reception: the stop-bit set must still show for a cycle.
      bus.clr_resp_rdy = 1'b1;
      rx_send(8'hC3, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      bus.clr_resp_rdy = 1'b0;
      check("set_wins_resp", 32'(bus.resp), 32'hC3);

      // Reset in the middle of the high frame.
      tx_mon_en = 1'b0;
      send(16'h5555, 1'b0);
      repeat (3 * BD) @(negedge clk);
      RST_n = 1'b0;
      @(negedge clk);
      check("midrst_TX", 32'(bus.TX), 32'd1);
      check("midrst_cmd_sent", 32'(bus.cmd_sent), 32'd0);
      check("midrst_resp", 32'(bus.resp), 32'h00);
      RST_n = 1'b1;
      repeat (200) @(negedge clk);
      tx_mon_en = 1'b1;

      send(16'h1234, 1'b1);
      wait_sent();
      repeat (20) @(negedge clk);

      check("tx_q_empty", 32'(tx_exp_q.size()), 32'd0);
      check("resp_q_empty", 32'(resp_exp_q.size()), 32'd0);
      check("sent_q_empty", 32'(sent_exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
